// File: rtl/hint_banner_ctrl.sv
// Hint-banner motion sequencer: slides a 224x28 banner in from below, holds, blinks,
// then slides it back out. All motion and counting advance only on frame_tick.
module hint_banner_ctrl #(
   parameter int unsigned CENTER_X     = 208,
   parameter int unsigned START_Y      = 480,
   parameter int unsigned TARGET_Y     = 226,
   parameter int unsigned STEP         = 8,
   parameter int unsigned HOLD_FRAMES  = 120,
   parameter int unsigned BLINK_FRAMES = 48,
   parameter int unsigned BLINK_PERIOD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       trigger,
   input  logic       dismiss,
   output logic [9:0] posx,
   output logic [8:0] posy,
   output logic       isplay,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SLIDE_IN  = 3'd1;
   localparam logic [2:0] ST_HOLD      = 3'd2;
   localparam logic [2:0] ST_BLINK     = 3'd3;
   localparam logic [2:0] ST_SLIDE_OUT = 3'd4;

   localparam logic [9:0] POSX_C     = 10'(CENTER_X);
   localparam logic [8:0] START_C    = 9'(START_Y);
   localparam logic [8:0] TARGET_C   = 9'(TARGET_Y);
   localparam logic [8:0] STEP_C     = 9'(STEP);
   localparam logic [9:0] START_W    = 10'(START_Y);
   localparam logic [9:0] STEP_W     = 10'(STEP);
   localparam logic [9:0] IN_LIMIT   = 10'(TARGET_Y + STEP);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES);
   localparam logic [7:0] PERIOD_C   = 8'(BLINK_PERIOD);

   logic [2:0] state_q, state_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic [7:0] phase_q, phase_d;
   logic [8:0] posy_d;
   logic       isplay_d;
   logic       done_d;

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      posy_d      = posy;
      isplay_d    = isplay;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Trigger beats dismiss here; a same-cycle tick causes no motion.
            if (trigger) begin
               state_d  = ST_SLIDE_IN;
               posy_d   = START_C;
               isplay_d = 1'b1;
            end
         end

         ST_SLIDE_IN: begin
            if (dismiss) begin
               state_d  = ST_SLIDE_OUT;
               isplay_d = 1'b1;
            end else if (frame_tick) begin
               // Widened compare so the step never underflows past the target.
               if ({1'b0, posy} <= IN_LIMIT) begin
                  posy_d     = TARGET_C;
                  state_d    = ST_HOLD;
                  hold_cnt_d = 8'd0;
               end else begin
                  posy_d = posy - STEP_C;
               end
            end
         end

         ST_HOLD: begin
            if (dismiss) begin
               state_d  = ST_SLIDE_OUT;
               isplay_d = 1'b1;
            end else if (trigger) begin
               hold_cnt_d = 8'd0;
               isplay_d   = 1'b1;
            end else if (frame_tick) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
               if (hold_cnt_q == HOLD_LAST) begin
                  state_d     = ST_BLINK;
                  blink_cnt_d = 8'd0;
                  phase_d     = 8'd0;
                  isplay_d    = 1'b1;
               end
            end
         end

         ST_BLINK: begin
            if (dismiss) begin
               state_d  = ST_SLIDE_OUT;
               isplay_d = 1'b1;
            end else if (trigger) begin
               state_d    = ST_HOLD;
               hold_cnt_d = 8'd0;
               isplay_d   = 1'b1;
            end else if (frame_tick) begin
               blink_cnt_d = blink_cnt_q + 8'd1;
               phase_d     = phase_q + 8'd1;
               // End of blink phase wins over a coincident toggle.
               if (blink_cnt_d == BLINK_LAST) begin
                  state_d  = ST_SLIDE_OUT;
                  isplay_d = 1'b1;
               end else if (phase_d == PERIOD_C) begin
                  isplay_d = ~isplay;
                  phase_d  = 8'd0;
               end
            end
         end

         ST_SLIDE_OUT: begin
            // Dismiss has nothing to do here but still outranks a trigger.
            if (trigger && !dismiss) begin
               state_d  = ST_SLIDE_IN;
               isplay_d = 1'b1;
            end else if (frame_tick) begin
               if (({1'b0, posy} + STEP_W) >= START_W) begin
                  posy_d   = START_C;
                  state_d  = ST_IDLE;
                  isplay_d = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  posy_d = posy + STEP_C;
               end
            end
         end

         default: begin
            state_d  = ST_IDLE;
            posy_d   = START_C;
            isplay_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_cnt_q  <= 8'd0;
         blink_cnt_q <= 8'd0;
         phase_q     <= 8'd0;
         posx        <= POSX_C;
         posy        <= START_C;
         isplay      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         posx        <= POSX_C;
         posy        <= posy_d;
         isplay      <= isplay_d;
         busy        <= (state_d != ST_IDLE);
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_hint_banner_ctrl.sv
// Self-checking bench for hint_banner_ctrl: directed scenarios against known positions,
// then random event streams against a frame-count reference model.
module tb_hint_banner_ctrl;

   localparam int START_Y = 480;
   localparam int TARGET_Y = 226;
   localparam int STEP = 8;
   localparam int HOLD_FRAMES = 120;
   localparam int BLINK_FRAMES = 48;
   localparam int BLINK_PERIOD = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0;
   logic       trigger = 1'b0;
   logic       dismiss = 1'b0;
   logic [9:0] posx;
   logic [8:0] posy;
   logic       isplay;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   hint_banner_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .trigger    (trigger),
      .dismiss    (dismiss),
      .posx       (posx),
      .posy       (posy),
      .isplay     (isplay),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Reference model: tracks which phase the banner is in and how many frames it has spent there.
   typedef enum {MIdle, MRise, MHold, MBlink, MFall} mphase_t;
   mphase_t m_ph = MIdle;
   int      m_y = START_Y;
   int      m_frames = 0;
   bit      m_vis = 1'b0;
   bit      m_done = 1'b0;

   function automatic void model_step(input bit r, input bit t, input bit d, input bit f);
      m_done = 1'b0;
      if (r) begin
         m_ph = MIdle; m_y = START_Y; m_vis = 1'b0; m_frames = 0;
         return;
      end
      case (m_ph)
         MIdle: if (t) begin m_ph = MRise; m_y = START_Y; m_vis = 1'b1; end
         MRise: begin
            if (d) begin m_ph = MFall; m_vis = 1'b1; end
            else if (f) begin
               if (m_y - STEP <= TARGET_Y) begin m_y = TARGET_Y; m_ph = MHold; m_frames = 0; end
               else m_y = m_y - STEP;
            end
         end
         MHold, MBlink: begin
            if (d) begin m_ph = MFall; m_vis = 1'b1; end
            else if (t) begin m_ph = MHold; m_frames = 0; m_vis = 1'b1; end
            else if (f) begin
               m_frames++;
               if (m_ph == MHold) begin
                  if (m_frames == HOLD_FRAMES) begin m_ph = MBlink; m_frames = 0; m_vis = 1'b1; end
               end else if (m_frames == BLINK_FRAMES) begin
                  m_ph = MFall; m_vis = 1'b1;
               end else begin
                  m_vis = ((m_frames / BLINK_PERIOD) % 2) == 0;
               end
            end
         end
         MFall: begin
            if (t && !d) begin m_ph = MRise; m_vis = 1'b1; end
            else if (f) begin
               if (m_y + STEP >= START_Y) begin
                  m_y = START_Y; m_ph = MIdle; m_vis = 1'b0; m_done = 1'b1;
               end else m_y = m_y + STEP;
            end
         end
         default: m_ph = MIdle;
      endcase
   endfunction

   task automatic step(input bit r, input bit t, input bit d, input bit f);
      rst = r; trigger = t; dismiss = d; frame_tick = f;
      model_step(r, t, d, f);
      @(posedge clk);
      #1;
      rst = 1'b0; trigger = 1'b0; dismiss = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset;
      int done_seen = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({posx, posy, isplay, busy, done} !== {10'd208, 9'd480, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got x=%0d y=%0d vis=%0b busy=%0b done=%0b want 208 480 0 0 0",
                  posx, posy, isplay, busy, done);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (done !== 1'b0 || busy !== 1'b0 || isplay !== 1'b0 || posy !== 9'd480) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL idle_ticks got %0d bad cycles want 0", done_seen);
      end
   endtask

   task automatic test_slide_in;
      int vis_bad = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({posy, isplay, busy} !== {9'd480, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL trigger_start got y=%0d vis=%0b busy=%0b want 480 1 1", posy, isplay, busy);
      end
      for (int k = 1; k <= 32; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (isplay !== 1'b1) vis_bad++;
         if (k == 1) begin
            checks++;
            if (posy !== 9'd472) begin
               errors++; $display("FAIL slide_in_t1 got %0d want 472", posy);
            end
         end else if (k == 31) begin
            checks++;
            if (posy !== 9'd232) begin
               errors++; $display("FAIL slide_in_t31 got %0d want 232", posy);
            end
         end else if (k == 32) begin
            checks++;
            if (posy !== 9'd226) begin
               errors++; $display("FAIL slide_in_t32 got %0d want 226", posy);
            end
         end
      end
      checks++;
      if (vis_bad != 0) begin
         errors++; $display("FAIL slide_in_vis got %0d hidden cycles want 0", vis_bad);
      end
   endtask

   task automatic test_full_cycle;
      int bad = 0;
      test_slide_in();
      for (int k = 1; k <= HOLD_FRAMES; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (posy !== 9'd226 || isplay !== 1'b1 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL hold_steady got %0d bad cycles want 0", bad);
      end
      bad = 0;
      for (int k = 1; k <= BLINK_FRAMES; k++) begin
         bit exp_vis;
         exp_vis = (k == BLINK_FRAMES) ? 1'b1 : (((k / BLINK_PERIOD) % 2) == 0);
         step(1'b0, 1'b0, 1'b0, 1'b1);
         checks++;
         if (isplay !== exp_vis) begin
            errors++; $display("FAIL blink_tick%0d got %0b want %0b", k, isplay, exp_vis);
         end
      end
      for (int k = 1; k <= 32; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (k < 32 && done !== 1'b0) bad++;
         if (k == 31) begin
            checks++;
            if ({posy, isplay, busy} !== {9'd474, 1'b1, 1'b1}) begin
               errors++;
               $display("FAIL slide_out_t31 got y=%0d vis=%0b busy=%0b want 474 1 1",
                        posy, isplay, busy);
            end
         end
      end
      checks++;
      if ({posy, isplay, busy, done} !== {9'd480, 1'b0, 1'b0, 1'b1} || bad != 0) begin
         errors++;
         $display("FAIL slide_out_end got y=%0d vis=%0b busy=%0b done=%0b early=%0d want 480 0 0 1 0",
                  posy, isplay, busy, done, bad);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_width got %0b want 0", done);
      end
   endtask

   task automatic test_dismiss;
      test_slide_in();
      ticks(5);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({posy, isplay, busy} !== {9'd226, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL dismiss_hold got y=%0d vis=%0b busy=%0b want 226 1 1", posy, isplay, busy);
      end
      ticks(32);
      checks++;
      if ({posy, isplay, busy, done} !== {9'd480, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL dismiss_exit got y=%0d vis=%0b busy=%0b done=%0b want 480 0 0 1",
                  posy, isplay, busy, done);
      end
   endtask

   task automatic test_retrigger;
      int n = 0;
      test_slide_in();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(10);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({posy, isplay, busy} !== {9'd306, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL retrigger_out got y=%0d vis=%0b busy=%0b want 306 1 1", posy, isplay, busy);
      end
      ticks(1);
      checks++;
      if (posy !== 9'd298) begin
         errors++; $display("FAIL retrigger_dir got %0d want 298", posy);
      end
      ticks(9);
      checks++;
      if (posy !== 9'd226) begin
         errors++; $display("FAIL retrigger_land got %0d want 226", posy);
      end
      step(1'b0, 1'b1, 1'b1, 1'b0);
      ticks(1);
      checks++;
      if ({posy, isplay} !== {9'd234, 1'b1}) begin
         errors++; $display("FAIL trig_dism_hold got y=%0d vis=%0b want 234 1", posy, isplay);
      end
      while (busy === 1'b1 && n < 100) begin
         ticks(1);
         n++;
      end
      checks++;
      if (busy !== 1'b0 || posy !== 9'd480) begin
         errors++; $display("FAIL retrigger_drain got busy=%0b y=%0d want 0 480", busy, posy);
      end
   endtask

   task automatic test_reset_mid_blink;
      test_slide_in();
      ticks(HOLD_FRAMES + BLINK_PERIOD + 2);
      checks++;
      if (isplay !== 1'b0) begin
         errors++; $display("FAIL blink_hidden got %0b want 0", isplay);
      end
      step(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({posy, isplay, busy, done} !== {9'd480, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_blink got y=%0d vis=%0b busy=%0b done=%0b want 480 0 0 0",
                  posy, isplay, busy, done);
      end
   endtask

   task automatic test_random;
      int trig_div[3] = '{25, 300, 3000};
      int dism_div[3] = '{60, 900, 5000};
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int seg = 0; seg < 3; seg++) begin
         for (int i = 0; i < 4000; i++) begin
            bit r, t, d, f;
            r = ($urandom_range(0, 1499) == 0);
            t = ($urandom_range(0, trig_div[seg] - 1) == 0);
            d = ($urandom_range(0, dism_div[seg] - 1) == 0);
            f = (seg == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
            step(r, t, d, f);
            checks++;
            if ({posx, posy, isplay, busy, done} !==
                {10'd208, 9'(m_y), m_vis, (m_ph != MIdle), m_done}) begin
               errors++;
               $display("FAIL random_seg%0d_cyc%0d got x=%0d y=%0d vis=%0b busy=%0b done=%0b want 208 %0d %0b %0b %0b",
                        seg, i, posx, posy, isplay, busy, done, m_y, m_vis, (m_ph != MIdle), m_done);
            end
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_slide_in();
      test_full_cycle();
      test_dismiss();
      test_retrigger();
      test_reset_mid_blink();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
